mem_io_bridge: RTL and testbench
================================

# mem_io_bridge

Parametrised, clocked successor to the combinational memory/IO splitter between the execute stage and data memory / peripherals. It decodes the ALU address into memory or one of `N_IO` peripheral windows and passes memory traffic through unchanged. IO accesses become a registered request/acknowledge transaction that stalls the CPU until the peripheral acknowledges or a timeout fires. Read data is zero-extended to the register-file width, and bad accesses are flagged with `bus_err`.

## Interface
- `DATA_W`, 32, register/memory data width
- `IO_W`, 16, peripheral data width (≤ `DATA_W`)
- `N_IO`, 4, number of peripheral channels
- `IO_BASE`, 32'hFFFFFC00, byte address of channel 0 window
- `IO_STRIDE`, 16, bytes per channel window (power of two)
- `TIMEOUT`, 15, max WAIT cycles before abort (≥ 1)

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `mRead` / `mWrite`  in  1  memory strobes from Controller
- `ioRead` / `ioWrite`  in  1  IO strobes from Controller
- `addr_in`  in  32  ALU result
- `r_rdata`  in  DATA_W  store data from register file
- `m_rdata`  in  DATA_W  data memory read data
- `addr_out`  out  32  address to data memory (= `addr_in`)
- `m_wdata`  out  DATA_W  memory write data (= `r_rdata`)
- `m_we`  out  1  memory write enable
- `io_sel`  out  N_IO  one-hot channel select, registered
- `io_rd` / `io_wr`  out  1  IO read/write request, registered
- `io_addr`  out  log2(IO_STRIDE)  offset within window, registered
- `io_wdata`  out  IO_W  `r_rdata[IO_W-1:0]`, latched
- `io_rdata`  in  N_IO*IO_W  channel k at bits [k*IO_W +: IO_W]
- `io_ack`  in  N_IO  per-channel acknowledge
- `r_wdata`  out  DATA_W  load result to register file
- `stall`  out  1  hold pipeline
- `bus_err`  out  1  one-cycle error pulse

## Operation
- Decode: `hit` when `IO_BASE ≤ addr_in < IO_BASE + N_IO*IO_STRIDE`; `ch = (addr_in - IO_BASE) / IO_STRIDE`; `io_addr = (addr_in - IO_BASE) % IO_STRIDE`.
- Memory path (combinational):
  - `m_we = mWrite & ~ioRead & ~ioWrite`.
  - `r_wdata = m_rdata` when `mRead` and state is IDLE.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - A request is `ioRead | ioWrite`.
  - Legal request (`hit`, not both io strobes, no m strobe): latch `ch`, `io_addr`, `io_wdata` and direction, clear counter → WAIT.
  - Illegal request: → DONE with error flag set and read data 0.
  - `stall` = 1 combinationally whenever a request is present.
- WAIT:
  - `io_sel[ch]` = 1; `io_rd` / `io_wr` per direction; `stall` = 1.
  - `io_ack[ch]` = 1: capture `io_rdata` channel `ch` (reads only), zero-extended → DONE.
  - Else increment counter. Counter == `TIMEOUT-1` without ack → DONE with error flag set and read data 0.
  - Acks on other channels are ignored.
- DONE:
  - `stall` = 0; `r_wdata` = captured data; `bus_err` = error flag; io request outputs low.
  - Always → IDLE. Strobes sampled in DONE belong to the completing instruction and are ignored.
- Writes return nothing; `r_wdata` in DONE after a write is 0.

## Timing
- Reset values: state IDLE, `io_sel` = 0, `io_rd` = `io_wr` = 0, `io_wdata` = 0, `io_addr` = 0, captured data 0, counter 0, `bus_err` = 0.
- Reset outputs in the same cycle: `stall` = 0; `m_we` and `r_wdata` follow their combinational rules.
- Reset mid-transaction: next edge returns to IDLE and drops `io_sel` / `io_rd` / `io_wr`. A late ack is ignored.
- Minimum IO latency (ack in first WAIT cycle): request cycle, 1 WAIT cycle, DONE. `stall` is high 2 cycles; the result is valid in cycle 3.
- Timeout: `stall` high `TIMEOUT+1` cycles, then DONE with `bus_err` = 1 for exactly 1 cycle.
- Illegal access: `stall` high 1 cycle, then DONE with `bus_err` = 1.
- Ack held high across several cycles completes once only; the FSM leaves WAIT on the first edge.
- Memory accesses never stall and never touch the FSM.

## Test plan
- Memory load/store: `mRead=1`, `addr_in=0x100`, `m_rdata=0xDEADBEEF` → `r_wdata=0xDEADBEEF`, `stall=0`. `mWrite=1` → `m_we=1`, `m_wdata=r_rdata`, `io_sel=0`.
- IO read, channel 2 (`addr_in=0xFFFFFC24`), ack on first WAIT cycle with ch2 data 0xA5A5 → `io_addr=4`; `stall` high 2 cycles; DONE `r_wdata=0x0000A5A5`, `bus_err=0`.
- IO write, channel 0, `r_rdata=0x12345678`, ack after 3 WAIT cycles → `io_wr=1`, `io_sel=4'b0001`, `io_wdata=0x5678` for 3 cycles. Meanwhile `io_ack[1]` pulses are ignored.
- Timeout: read channel 3 with no ack, `TIMEOUT=15` → `stall` high 16 cycles, `r_wdata=0`, `bus_err` pulses 1 cycle, back to IDLE.
- Illegal access: `ioRead=1`, `addr_in=0xFFFFFC40` (beyond `N_IO`), and separately `ioRead & mRead` together → each gives 1 stall cycle, `bus_err=1`, `io_sel` never asserted.
- `reset=1` in the 2nd WAIT cycle → next cycle `io_sel=0`, `io_rd=0`, `stall=0`, state IDLE. An ack following reset has no effect.

Source files
------------

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: routes execute-stage accesses to data memory (combinational
// pass-through) or to one of N_IO peripheral windows via a registered
// request/acknowledge handshake with a timeout. Bad accesses pulse bus_err.
module mem_io_bridge #(
  parameter int          DATA_W    = 32,
  parameter int          IO_W      = 16,
  parameter int          N_IO      = 4,
  parameter logic [31:0] IO_BASE   = 32'hFFFFFC00,
  parameter int          IO_STRIDE = 16,
  parameter int          TIMEOUT   = 15
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         mRead,
  input  logic                         mWrite,
  input  logic                         ioRead,
  input  logic                         ioWrite,
  input  logic [31:0]                  addr_in,
  input  logic [DATA_W-1:0]            r_rdata,
  input  logic [DATA_W-1:0]            m_rdata,
  output logic [31:0]                  addr_out,
  output logic [DATA_W-1:0]            m_wdata,
  output logic                         m_we,
  output logic [N_IO-1:0]              io_sel,
  output logic                         io_rd,
  output logic                         io_wr,
  output logic [$clog2(IO_STRIDE)-1:0] io_addr,
  output logic [IO_W-1:0]              io_wdata,
  input  logic [N_IO*IO_W-1:0]         io_rdata,
  input  logic [N_IO-1:0]              io_ack,
  output logic [DATA_W-1:0]            r_wdata,
  output logic                         stall,
  output logic                         bus_err
);

  localparam int          AW      = $clog2(IO_STRIDE);
  localparam int          CH_W    = (N_IO > 1) ? $clog2(N_IO) : 1;
  localparam int          CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [32:0] IO_SPAN = 33'(N_IO) * 33'(IO_STRIDE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  // One-hot channel select for the latched channel index.
  function automatic logic [N_IO-1:0] ch_onehot(input logic [CH_W-1:0] c);
    logic [N_IO-1:0] oh;
    oh = '0;
    for (int k = 0; k < N_IO; k++) begin
      oh[k] = (c == CH_W'(k));
    end
    return oh;
  endfunction

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [AW-1:0]       io_addr_q, io_addr_d;
  logic [IO_W-1:0]     io_wdata_q, io_wdata_d;
  logic                is_wr_q, is_wr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [N_IO-1:0]     io_sel_q, io_sel_d;
  logic                io_rd_q, io_rd_d;
  logic                io_wr_q, io_wr_d;

  logic [31:0]         offset;
  logic                hit;
  logic [CH_W-1:0]     ch_dec;
  logic                io_req;
  logic                legal;
  logic [IO_W-1:0]     ch_rdata;

  // Address decode: window hit, channel index and in-window offset.
  always_comb begin
    offset = addr_in - IO_BASE;
    hit    = (addr_in >= IO_BASE) && ({1'b0, offset} < IO_SPAN);
    ch_dec = offset[AW +: CH_W];
    io_req = ioRead | ioWrite;
    legal  = hit & ~(ioRead & ioWrite) & ~(mRead | mWrite);
  end

  // Read data of the channel currently being served.
  always_comb begin
    ch_rdata = io_rdata[int'(ch_q) * IO_W +: IO_W];
  end

  // Transaction FSM next state and next register values.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    io_addr_d  = io_addr_q;
    io_wdata_d = io_wdata_q;
    is_wr_d    = is_wr_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (io_req) begin
          if (legal) begin
            ch_d       = ch_dec;
            io_addr_d  = offset[AW-1:0];
            io_wdata_d = r_rdata[IO_W-1:0];
            is_wr_d    = ioWrite;
            cnt_d      = '0;
            err_d      = 1'b0;
            rdata_d    = '0;
            state_d    = S_WAIT;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_DONE;
          end
        end
      end
      S_WAIT: begin
        if (io_ack[ch_q]) begin
          // Writes return nothing; reads are zero-extended.
          rdata_d = is_wr_q ? '0 : DATA_W'(ch_rdata);
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        // Strobes seen here belong to the instruction now completing.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Request outputs are registered: asserted exactly while in WAIT.
    io_sel_d = (state_d == S_WAIT) ? ch_onehot(ch_d) : '0;
    io_rd_d  = (state_d == S_WAIT) & ~is_wr_d;
    io_wr_d  = (state_d == S_WAIT) & is_wr_d;
  end

  // State and transaction registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      io_addr_q  <= '0;
      io_wdata_q <= '0;
      is_wr_q    <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      io_sel_q   <= '0;
      io_rd_q    <= 1'b0;
      io_wr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      io_addr_q  <= io_addr_d;
      io_wdata_q <= io_wdata_d;
      is_wr_q    <= is_wr_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      io_sel_q   <= io_sel_d;
      io_rd_q    <= io_rd_d;
      io_wr_q    <= io_wr_d;
    end
  end

  // Memory pass-through, stall, load result and error outputs.
  always_comb begin
    addr_out = addr_in;
    m_wdata  = r_rdata;
    m_we     = mWrite & ~ioRead & ~ioWrite;
    io_sel   = io_sel_q;
    io_rd    = io_rd_q;
    io_wr    = io_wr_q;
    io_addr  = io_addr_q;
    io_wdata = io_wdata_q;
    stall    = ~reset & (((state_q == S_IDLE) & io_req) | (state_q == S_WAIT));
    bus_err  = (state_q == S_DONE) & err_q;
    r_wdata  = '0;
    if ((state_q == S_IDLE) && mRead) begin
      r_wdata = m_rdata;
    end else if (state_q == S_DONE) begin
      r_wdata = rdata_q;
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed self-checking bench for mem_io_bridge (default parameters).
module tb_mem_io_bridge;

  logic        clock, reset;
  logic        mRead, mWrite, ioRead, ioWrite;
  logic [31:0] addr_in;
  logic [31:0] r_rdata, m_rdata;
  logic [31:0] addr_out;
  logic [31:0] m_wdata;
  logic        m_we;
  logic [3:0]  io_sel;
  logic        io_rd, io_wr;
  logic [3:0]  io_addr;
  logic [15:0] io_wdata;
  logic [63:0] io_rdata;
  logic [3:0]  io_ack;
  logic [31:0] r_wdata;
  logic        stall, bus_err;

  int total;
  int bad;

  mem_io_bridge dut (
    .clock(clock), .reset(reset),
    .mRead(mRead), .mWrite(mWrite), .ioRead(ioRead), .ioWrite(ioWrite),
    .addr_in(addr_in), .r_rdata(r_rdata), .m_rdata(m_rdata),
    .addr_out(addr_out), .m_wdata(m_wdata), .m_we(m_we),
    .io_sel(io_sel), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack),
    .r_wdata(r_wdata), .stall(stall), .bus_err(bus_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change 1 time unit after a rising edge; outputs are sampled 4 later.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    mRead = 0; mWrite = 0; ioRead = 0; ioWrite = 0;
    addr_in = 32'h0; r_rdata = 32'h0; m_rdata = 32'h0;
    io_rdata = 64'h0; io_ack = 4'b0;
  endtask

  task automatic test_reset();
    next_cycle();
    ioRead = 1; mRead = 1; addr_in = 32'hFFFFFC24; m_rdata = 32'h01234567;
    #4;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
    total++; if (io_sel !== 4'b0) begin bad++; $display("FAIL rst_io_sel got=%b exp=0000", io_sel); end
    total++; if ({io_rd, io_wr, bus_err} !== 3'b0) begin bad++; $display("FAIL rst_rd_wr_err got=%b exp=000", {io_rd, io_wr, bus_err}); end
    total++; if ({io_wdata, io_addr} !== 20'h0) begin bad++; $display("FAIL rst_wdata_addr got=%h exp=00000", {io_wdata, io_addr}); end
    total++; if (r_wdata !== 32'h01234567) begin bad++; $display("FAIL rst_r_wdata got=%h exp=01234567", r_wdata); end
    next_cycle();
    idle_inputs();
    reset = 0;
    #4;
    total++; if (stall !== 1'b0 || io_sel !== 4'b0) begin bad++; $display("FAIL rst_release got stall=%b sel=%b exp 0/0000", stall, io_sel); end
  endtask

  task automatic test_memory();
    next_cycle();
    mRead = 1; addr_in = 32'h100; m_rdata = 32'hDEADBEEF;
    #4;
    total++; if (r_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL mem_load got=%h exp=deadbeef", r_wdata); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL mem_load_stall got=%b exp=0", stall); end
    total++; if (addr_out !== 32'h100) begin bad++; $display("FAIL mem_addr got=%h exp=00000100", addr_out); end
    next_cycle();
    mRead = 0; mWrite = 1; addr_in = 32'h204; r_rdata = 32'hCAFEF00D;
    #4;
    total++; if (m_we !== 1'b1) begin bad++; $display("FAIL mem_we got=%b exp=1", m_we); end
    total++; if (m_wdata !== 32'hCAFEF00D) begin bad++; $display("FAIL mem_wdata got=%h exp=cafef00d", m_wdata); end
    next_cycle();
    idle_inputs();
    #4;
    total++; if (io_sel !== 4'b0 || stall !== 1'b0 || bus_err !== 1'b0) begin bad++; $display("FAIL mem_no_fsm got sel=%b stall=%b err=%b exp 0000/0/0", io_sel, stall, bus_err); end
  endtask

  // Read ch2 with first-cycle ack held into DONE, then an immediate read of ch3.
  task automatic test_io_read();
    next_cycle();
    ioRead = 1; addr_in = 32'hFFFFFC24; io_rdata = 64'h3333_A5A5_1111_0F0F;
    #4;
    total++; if (stall !== 1'b1 || io_sel !== 4'b0) begin bad++; $display("FAIL rd_req got stall=%b sel=%b exp 1/0000", stall, io_sel); end
    next_cycle();
    io_ack = 4'b0100;
    #4;
    total++; if (io_sel !== 4'b0100) begin bad++; $display("FAIL rd_wait_sel got=%b exp=0100", io_sel); end
    total++; if ({io_rd, io_wr, stall} !== 3'b101) begin bad++; $display("FAIL rd_wait_rd_wr_stall got=%b exp=101", {io_rd, io_wr, stall}); end
    total++; if (io_addr !== 4'h4) begin bad++; $display("FAIL rd_io_addr got=%h exp=4", io_addr); end
    next_cycle();
    #4;
    total++; if (stall !== 1'b0 || bus_err !== 1'b0) begin bad++; $display("FAIL rd_done got stall=%b err=%b exp 0/0", stall, bus_err); end
    total++; if (r_wdata !== 32'h0000A5A5) begin bad++; $display("FAIL rd_done_data got=%h exp=0000a5a5", r_wdata); end
    total++; if (io_sel !== 4'b0 || io_rd !== 1'b0) begin bad++; $display("FAIL rd_done_req got sel=%b rd=%b exp 0000/0", io_sel, io_rd); end
    next_cycle();
    addr_in = 32'hFFFFFC3A; io_ack = 4'b0000;
    #4;
    total++; if (stall !== 1'b1 || io_sel !== 4'b0) begin bad++; $display("FAIL b2b_req got stall=%b sel=%b exp 1/0000", stall, io_sel); end
    next_cycle();
    io_ack = 4'b1000;
    #4;
    total++; if (io_sel !== 4'b1000 || io_addr !== 4'hA) begin bad++; $display("FAIL b2b_wait got sel=%b addr=%h exp 1000/a", io_sel, io_addr); end
    next_cycle();
    ioRead = 0; io_ack = 4'b0;
    #4;
    total++; if (r_wdata !== 32'h00003333 || stall !== 1'b0) begin bad++; $display("FAIL b2b_done got data=%h stall=%b exp 00003333/0", r_wdata, stall); end
    next_cycle();
    idle_inputs();
  endtask

  // Write ch0, ack on the third WAIT cycle, foreign ch1 acks ignored.
  task automatic test_io_write();
    ioWrite = 1; addr_in = 32'hFFFFFC06; r_rdata = 32'h12345678;
    #4;
    total++; if (stall !== 1'b1 || m_we !== 1'b0) begin bad++; $display("FAIL wr_req got stall=%b we=%b exp 1/0", stall, m_we); end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      r_rdata = 32'hFFFF0000;
      io_ack = (i == 2) ? 4'b0011 : ((i == 0) ? 4'b0010 : 4'b0000);
      io_rdata = 64'h0000_0000_0000_BEEF;
      #4;
      total++; if ({io_wr, io_rd, stall} !== 3'b101 || io_sel !== 4'b0001) begin bad++; $display("FAIL wr_wait%0d got wr/rd/stall=%b sel=%b exp 101/0001", i, {io_wr, io_rd, stall}, io_sel); end
      total++; if (io_wdata !== 16'h5678 || io_addr !== 4'h6) begin bad++; $display("FAIL wr_latch%0d got wdata=%h addr=%h exp 5678/6", i, io_wdata, io_addr); end
    end
    next_cycle();
    ioWrite = 0; io_ack = 4'b0;
    #4;
    total++; if (stall !== 1'b0 || bus_err !== 1'b0 || r_wdata !== 32'h0) begin bad++; $display("FAIL wr_done got stall=%b err=%b data=%h exp 0/0/0", stall, bus_err, r_wdata); end
    total++; if (io_wr !== 1'b0 || io_sel !== 4'b0) begin bad++; $display("FAIL wr_done_req got wr=%b sel=%b exp 0/0000", io_wr, io_sel); end
    next_cycle();
    idle_inputs();
  endtask

  // Read ch3 never acked (other channels ack constantly).
  task automatic test_timeout();
    int n;
    n = 0;
    ioRead = 1; addr_in = 32'hFFFFFC30; io_rdata = 64'h3333_2222_1111_0000; io_ack = 4'b0111;
    for (int i = 0; i < 40; i++) begin
      #4;
      if (stall !== 1'b1) break;
      n++;
      total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL to_err_early cycle=%0d got=%b exp=0", n, bus_err); end
      next_cycle();
    end
    total++; if (n !== 16) begin bad++; $display("FAIL to_stall_len got=%0d exp=16", n); end
    total++; if (bus_err !== 1'b1 || r_wdata !== 32'h0) begin bad++; $display("FAIL to_done got err=%b data=%h exp 1/0", bus_err, r_wdata); end
    next_cycle();
    idle_inputs();
    #4;
    total++; if (bus_err !== 1'b0 || stall !== 1'b0 || io_sel !== 4'b0) begin bad++; $display("FAIL to_after got err=%b stall=%b sel=%b exp 0/0/0000", bus_err, stall, io_sel); end
    next_cycle();
  endtask

  // Out-of-window address, IO+mem strobes, and mWrite+ioWrite.
  task automatic test_illegal();
    for (int k = 0; k < 3; k++) begin
      idle_inputs();
      if (k == 0) begin ioRead = 1; addr_in = 32'hFFFFFC40; end
      else if (k == 1) begin ioRead = 1; mRead = 1; addr_in = 32'hFFFFFC24; m_rdata = 32'h55; end
      else begin ioWrite = 1; mWrite = 1; addr_in = 32'hFFFFFC14; end
      io_rdata = 64'hFFFF_FFFF_FFFF_FFFF; io_ack = 4'b1111;
      #4;
      total++; if (stall !== 1'b1 || io_sel !== 4'b0 || m_we !== 1'b0) begin bad++; $display("FAIL ill%0d_req got stall=%b sel=%b we=%b exp 1/0000/0", k, stall, io_sel, m_we); end
      next_cycle();
      #4;
      total++; if (stall !== 1'b0 || bus_err !== 1'b1 || r_wdata !== 32'h0) begin bad++; $display("FAIL ill%0d_done got stall=%b err=%b data=%h exp 0/1/0", k, stall, bus_err, r_wdata); end
      total++; if (io_sel !== 4'b0 || io_rd !== 1'b0 || io_wr !== 1'b0) begin bad++; $display("FAIL ill%0d_sel got sel=%b rd=%b wr=%b exp 0000/0/0", k, io_sel, io_rd, io_wr); end
      next_cycle();
      idle_inputs();
      #4;
      total++; if (bus_err !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL ill%0d_after got err=%b stall=%b exp 0/0", k, bus_err, stall); end
      next_cycle();
    end
  endtask

  // Reset asserted in the second WAIT cycle of a ch1 read; late ack follows.
  task automatic test_reset_mid();
    ioRead = 1; addr_in = 32'hFFFFFC10; io_rdata = 64'h0000_0000_4444_0000;
    next_cycle();
    #4;
    total++; if (io_sel !== 4'b0010) begin bad++; $display("FAIL rm_wait1 got sel=%b exp=0010", io_sel); end
    next_cycle();
    reset = 1;
    #4;
    total++; if (stall !== 1'b0 || io_sel !== 4'b0010) begin bad++; $display("FAIL rm_rst_cycle got stall=%b sel=%b exp 0/0010", stall, io_sel); end
    next_cycle();
    reset = 0; ioRead = 0; io_ack = 4'b0010;
    #4;
    total++; if (io_sel !== 4'b0 || io_rd !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rm_after got sel=%b rd=%b stall=%b exp 0000/0/0", io_sel, io_rd, stall); end
    next_cycle();
    io_ack = 4'b0; mRead = 1; m_rdata = 32'h77;
    #4;
    total++; if (bus_err !== 1'b0 || r_wdata !== 32'h77 || io_sel !== 4'b0) begin bad++; $display("FAIL rm_idle got err=%b data=%h sel=%b exp 0/00000077/0000", bus_err, r_wdata, io_sel); end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    reset = 1;
    idle_inputs();
    test_reset();
    test_memory();
    test_io_read();
    test_io_write();
    test_timeout();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
